// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the baccarat round controller.
// Optional feature macro: BACCARAT_AUTO_ROUND_EN (see baccarat_fsm.sv).
package baccarat_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    D1   = 3'd2,
    P2   = 3'd3,
    D2   = 3'd4,
    P3   = 3'd5,
    D3   = 3'd6,
    DONE = 3'd7
  } state_t;

  // Two-card totals at or above this end the round immediately.
  localparam int NATURAL_MIN      = 8;
  // Player stands on this total or higher; banker draw threshold when player stands.
  localparam int PLAYER_STAND_MIN = 6;

  // Baccarat point value of a raw card: 10/J/Q/K count as 0, A..9 at face value.
  function automatic logic [3:0] card_value(input logic [7:0] raw);
    return (raw >= 8'd10) ? 4'd0 : raw[3:0];
  endfunction

endpackage

// File: rtl/baccarat_fsm_if.sv
// Controller <-> card datapath bundle: load strobes, score read-back and win lights.
// master = round controller, slave = card datapath.
interface baccarat_fsm_if #(
  parameter int CARD_W  = 4,
  parameter int SCORE_W = 4
);
  logic [SCORE_W-1:0] pscore;
  logic [SCORE_W-1:0] dscore;
  logic [CARD_W-1:0]  pcard3;
  logic               load_pcard1;
  logic               load_pcard2;
  logic               load_pcard3;
  logic               load_dcard1;
  logic               load_dcard2;
  logic               load_dcard3;
  logic               player_win_light;
  logic               dealer_win_light;
  logic               new_round;

  modport master (
    input  pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light, new_round
  );

  modport slave (
    output pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light, new_round
  );
endinterface

// File: rtl/baccarat_banker_rule.sv
// Banker third-card rule: given the banker two-card total and the point value
// of the player's third card, decide whether the banker draws.
module baccarat_banker_rule #(
  parameter int SCORE_W = 4
) (
  input  logic [SCORE_W-1:0] dscore,
  input  logic [3:0]         v,
  output logic               draw
);

  // Drawing table indexed by banker total, qualified by player third-card value.
  always_comb begin
    draw = 1'b0;
    if (dscore <= SCORE_W'(2))
      draw = 1'b1;
    else if (dscore == SCORE_W'(3))
      draw = (v != 4'd8);
    else if (dscore == SCORE_W'(4))
      draw = (v >= 4'd2) && (v <= 4'd7);
    else if (dscore == SCORE_W'(5))
      draw = (v >= 4'd4) && (v <= 4'd7);
    else if (dscore == SCORE_W'(6))
      draw = (v >= 4'd6) && (v <= 4'd7);
  end

endmodule

// File: rtl/baccarat_fsm.sv
// Baccarat round controller: sequences card loads into the datapath, applies
// the third-card rules and lights the winner outputs. One card per slow_clock.
// Optional feature macro: BACCARAT_AUTO_ROUND_EN -- after DONE_HOLD cycles in
// DONE, pulse new_round for one cycle and restart; otherwise DONE is terminal.
module baccarat_fsm
  import baccarat_pkg::*;
#(
  parameter int CARD_W    = 4,
  parameter int SCORE_W   = 4,
  parameter int DONE_HOLD = 8
) (
  input  logic           slow_clock,
  input  logic           reset,
  baccarat_fsm_if.master bus
);

  state_t     state;
  state_t     state_next;
  logic [3:0] pcard3_value;
  logic       banker_draws;
  logic       release_next;
  logic       lights_next;

  assign pcard3_value = card_value(8'(bus.pcard3));

  baccarat_banker_rule #(.SCORE_W(SCORE_W)) u_banker_rule (
    .dscore (bus.dscore),
    .v      (pcard3_value),
    .draw   (banker_draws)
  );

`ifdef BACCARAT_AUTO_ROUND_EN
  localparam int HOLD_W = (DONE_HOLD < 1) ? 1 : $clog2(DONE_HOLD + 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_next;

  // Hold counter runs only while staying in DONE; any other path clears it.
  always_comb begin
    hold_next = '0;
    if (state == DONE && state_next == DONE)
      hold_next = hold_cnt + HOLD_W'(1);
    release_next = (state_next == DONE) && (hold_next == HOLD_W'(DONE_HOLD));
  end
`else
  assign release_next = 1'b0;
`endif

  // Next-state decision from scores sampled at the edge leaving each strobe state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = P1;
      P1:   state_next = D1;
      D1:   state_next = P2;
      P2:   state_next = D2;
      D2: begin
        if (bus.pscore >= SCORE_W'(NATURAL_MIN) || bus.dscore >= SCORE_W'(NATURAL_MIN))
          state_next = DONE;
        else if (bus.pscore < SCORE_W'(PLAYER_STAND_MIN))
          state_next = P3;
        else if (bus.dscore < SCORE_W'(PLAYER_STAND_MIN))
          state_next = D3;
        else
          state_next = DONE;
      end
      P3:   state_next = banker_draws ? D3 : DONE;
      D3:   state_next = DONE;
      DONE: begin
`ifdef BACCARAT_AUTO_ROUND_EN
        state_next = (hold_cnt == HOLD_W'(DONE_HOLD)) ? IDLE : DONE;
`else
        state_next = DONE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Lights are off during the new_round cycle even though the state is still DONE.
  assign lights_next = (state_next == DONE) && !release_next;

  // State register with outputs registered from the next-state decode.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state                <= IDLE;
      bus.load_pcard1      <= 1'b0;
      bus.load_dcard1      <= 1'b0;
      bus.load_pcard2      <= 1'b0;
      bus.load_dcard2      <= 1'b0;
      bus.load_pcard3      <= 1'b0;
      bus.load_dcard3      <= 1'b0;
      bus.player_win_light <= 1'b0;
      bus.dealer_win_light <= 1'b0;
      bus.new_round        <= 1'b0;
`ifdef BACCARAT_AUTO_ROUND_EN
      hold_cnt             <= '0;
`endif
    end else begin
      state                <= state_next;
      bus.load_pcard1      <= (state_next == P1);
      bus.load_dcard1      <= (state_next == D1);
      bus.load_pcard2      <= (state_next == P2);
      bus.load_dcard2      <= (state_next == D2);
      bus.load_pcard3      <= (state_next == P3);
      bus.load_dcard3      <= (state_next == D3);
      bus.player_win_light <= lights_next && (bus.pscore >= bus.dscore);
      bus.dealer_win_light <= lights_next && (bus.dscore >= bus.pscore);
      bus.new_round        <= release_next;
`ifdef BACCARAT_AUTO_ROUND_EN
      hold_cnt             <= hold_next;
`endif
    end
  end

endmodule
